controlador_es: RTL
===================

# controlador_es

Clock-enable and I/O handshake controller sitting directly upstream of `cpu`. Watches the control unit's `OpIn`/`OpOut`/`OpHalt` decode, freezes the CPU on an input instruction until the user confirms with a debounced pushbutton, and latches the output value for the seven-segment driver. It also stops the CPU permanently on halt. It is the only block allowed to pause program execution.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 50000: consecutive stable samples needed to accept a button level change (1 ms at 50 MHz).
- `DATA_WIDTH`, 28: width of the output value bus.

Ports:
- `clock`  in  1  system clock; shared with `cpu`.
- `reset`  in  1  synchronous, active-high reset.
- `botao`  in  1  raw confirm pushbutton; asynchronous, active-low (pressed = 0).
- `OpIn`  in  1  current instruction is IN.
- `OpOut`  in  1  current instruction is OUT.
- `OpHalt`  in  1  current instruction is HALT.
- `dado_saida`  in  DATA_WIDTH  value on the CPU output bus (register read port 2).
- `cpu_enable`  out  1  clock enable for `cpu`. It gates PC update, register-file writes and RAM writes.
- `display_reg`  out  DATA_WIDTH  latched output value for the display decoders.
- `esperando`  out  1  high while waiting for confirmation (LED).
- `parado`  out  1  high once halted (LED).

## Operation
- Input conditioning:
  - `botao` passes through a 2-flop synchronizer and is inverted.
  - A debouncer holds a stable level, initially released.
  - The counter increments while the synchronized sample differs from the stable level and clears when they match.
  - When the counter reaches `DEBOUNCE_CYCLES`, the stable level flips and the counter clears.
  - `confirma` is a one-cycle pulse generated on the released→pressed transition of the stable level. Release produces no pulse.
- FSM states: `EXECUTA`, `ESPERA`, `LIBERA`, `PARADO`.
- `EXECUTA`:
  - `OpHalt` → `PARADO`. Halt has priority over `OpIn`/`OpOut`.
  - else `OpIn` → `ESPERA`.
  - else stay. `confirma` is ignored and discarded.
- `ESPERA`: `confirma` → `LIBERA`, else stay.
- `LIBERA`: unconditionally → `EXECUTA`.
- `PARADO`: stays until `reset`.
- `cpu_enable` (Mealy):
  - 1 in `EXECUTA` when neither `OpIn` nor `OpHalt` is high.
  - 1 in `LIBERA`. This is the single cycle in which the IN instruction commits the switch value.
  - 0 otherwise, and 0 while `reset` is high.
- `esperando` = state is `ESPERA`. `parado` = state is `PARADO`. Both are registered decodes of state.
- `display_reg` loads `dado_saida` on any cycle where state is `EXECUTA` and `OpOut` is high. Otherwise it holds.
- Back-to-back IN instructions each require a separate press: release, then press again.

## Timing
- Reset values:
  - state `EXECUTA`
  - `display_reg` 0
  - `esperando` 0, `parado` 0
  - debouncer: stable level released, counter 0
  - synchronizer flops 1 (released)
  - `cpu_enable` 0 during the reset cycle.
- Stall latency:
  - `cpu_enable` drops in the same cycle `OpIn` or `OpHalt` asserts. No instruction commits before the stall.
- Press-to-commit latency:
  - `confirma` asserts 2 + `DEBOUNCE_CYCLES` cycles after `botao` falls, assuming the button stays stable.
  - `LIBERA` follows 1 cycle later, and the CPU commits on that cycle's edge.
- Bounce shorter than `DEBOUNCE_CYCLES` produces no pulse.
- A press already held when entering `ESPERA` does not confirm. A fresh press edge is required.
- Reset mid-`ESPERA` or mid-`PARADO` returns to `EXECUTA` on the next edge. A pending debounce count is lost.

## Configuration
- `ES_OUT_PAUSE_EN`:
  - Defined: OUT behaves like IN. In `EXECUTA`, `OpOut` (without `OpHalt`) → `ESPERA`, and `cpu_enable` is 0 that cycle. `display_reg` loads on entry, so the user reads the value and presses to continue.
  - Undefined: OUT never stalls. The latch still occurs in the cycle the OUT instruction executes.

## Structure
- Package `es_pkg`:
  - state enum `estado_es_t`.
  - default `DEBOUNCE_CYCLES` constant.
- Sub-module `debouncer_botao`:
  - contains the synchronizer, counter and pulse generator.
  - counter width is $clog2(`DEBOUNCE_CYCLES`+1).
  - outputs: `estavel`, `confirma`.
- Top contains the FSM, enable decode and output latch.

## Test plan
Use `DEBOUNCE_CYCLES`=4 for all scenarios.
- Reset held 3 cycles, then released with all Op* low → `cpu_enable`=0 during reset, then 1; `display_reg`=0; `esperando`=`parado`=0.
- `OpIn`=1 steady; `botao` low for 10 cycles → `cpu_enable`=0 and `esperando`=1 until `LIBERA`. `LIBERA` occurs exactly 7 cycles after `botao` falls. `cpu_enable`=1 for exactly one cycle, then `OpIn` still high re-enters `ESPERA`.
- Bounce: `botao` toggles every 2 cycles for 20 cycles while in `ESPERA` → no `confirma`; state stays `ESPERA`.
- `OpOut`=1 with `dado_saida`=28'h0ABCDEF for one cycle, macro undefined → `display_reg`=28'h0ABCDEF next cycle; `cpu_enable` stays 1.
- `OpHalt`=1 together with `OpIn`=1 → `PARADO`, `parado`=1, `cpu_enable`=0 permanently. Button presses are ignored. `reset` restores `EXECUTA`.
- Macro defined; `OpOut`=1 with `dado_saida`=28'h1234567 → `ESPERA`, `display_reg`=28'h1234567; after a press, one `LIBERA` enable cycle.

Source files
------------

// File: rtl/es_pkg.sv
// Shared types and defaults for the controlador_es I/O handshake controller.
package es_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 50000;
    localparam int DATA_WIDTH_DEF      = 28;

    typedef enum logic [1:0] {
        EXECUTA = 2'd0,
        ESPERA  = 2'd1,
        LIBERA  = 2'd2,
        PARADO  = 2'd3
    } estado_es_t;

endpackage

// File: rtl/controlador_es_if.sv
// Bundle between the CPU control unit and controlador_es: instruction decode
// and output bus in, clock enable, display latch and status LEDs out.
interface controlador_es_if
    import es_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                  OpIn;
    logic                  OpOut;
    logic                  OpHalt;
    logic [DATA_WIDTH-1:0] dado_saida;
    logic                  cpu_enable;
    logic [DATA_WIDTH-1:0] display_reg;
    logic                  esperando;
    logic                  parado;

    modport master (
        output OpIn, OpOut, OpHalt, dado_saida,
        input  cpu_enable, display_reg, esperando, parado
    );

    modport slave (
        input  OpIn, OpOut, OpHalt, dado_saida,
        output cpu_enable, display_reg, esperando, parado
    );

endinterface

// File: rtl/debouncer_botao.sv
// Synchronizes and debounces the active-low confirm button; emits a one-cycle
// confirma pulse on each accepted press (release produces no pulse).
module debouncer_botao #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic botao,
    output logic estavel,
    output logic confirma
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic             amostra;
    logic [CNT_W-1:0] contador;

    assign amostra = ~sync2;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= botao;
            sync2 <= sync1;
        end
    end

    // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            estavel  <= 1'b0;
            contador <= '0;
            confirma <= 1'b0;
        end else begin
            confirma <= 1'b0;
            if (amostra == estavel) begin
                contador <= '0;
            end else if (contador == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                estavel  <= amostra;
                contador <= '0;
                confirma <= amostra;
            end else begin
                contador <= contador + 1'b1;
            end
        end
    end

endmodule

// File: rtl/controlador_es.sv
// CPU clock-enable controller: stalls on IN until a debounced press, latches OUT
// values, stops on HALT. Define ES_OUT_PAUSE_EN to make OUT stall like IN.
module controlador_es
    import es_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             botao,
    controlador_es_if.slave  bus
);

    estado_es_t            estado;
    estado_es_t            proximo;
    logic                  estavel;
    logic                  confirma;
    logic                  pausa_op;
    logic                  esperando_q;
    logic                  parado_q;
    logic [DATA_WIDTH-1:0] display_q;

    debouncer_botao #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock    (clock),
        .reset    (reset),
        .botao    (botao),
        .estavel  (estavel),
        .confirma (confirma)
    );

`ifdef ES_OUT_PAUSE_EN
    assign pausa_op = bus.OpIn | bus.OpOut;
`else
    assign pausa_op = bus.OpIn;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= EXECUTA;
        end else begin
            estado <= proximo;
        end
    end

    // confirma and estavel rise on the same edge, so the guard only rejects a stray pulse.
    always_comb begin
        proximo = estado;
        case (estado)
            EXECUTA: begin
                if (bus.OpHalt) begin
                    proximo = PARADO;
                end else if (pausa_op) begin
                    proximo = ESPERA;
                end
            end
            ESPERA: begin
                if (confirma && estavel) begin
                    proximo = LIBERA;
                end
            end
            LIBERA:  proximo = EXECUTA;
            PARADO:  proximo = PARADO;
            default: proximo = EXECUTA;
        endcase
    end

    always_comb begin
        bus.cpu_enable = 1'b0;
        if (!reset) begin
            case (estado)
                EXECUTA: bus.cpu_enable = !bus.OpHalt && !pausa_op;
                LIBERA:  bus.cpu_enable = 1'b1;
                default: bus.cpu_enable = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            esperando_q <= 1'b0;
            parado_q    <= 1'b0;
            display_q   <= '0;
        end else begin
            esperando_q <= (proximo == ESPERA);
            parado_q    <= (proximo == PARADO);
            if (estado == EXECUTA && bus.OpOut) begin
                display_q <= bus.dado_saida;
            end
        end
    end

    assign bus.esperando   = esperando_q;
    assign bus.parado      = parado_q;
    assign bus.display_reg = display_q;

endmodule
